mult4_sched: RTL
================

MULT4_SCHED -- requirements
Module: mult4_sched

Interface
REQ-001 The block SHALL have exactly the following ports, in this order:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- REQ0  input  1  requester 0 has an operation pending.
- A0  input  4  requester 0 multiplicand.
- B0  input  4  requester 0 multiplier.
- GNT0  output  1  requester 0 operands accepted this cycle.
- REQ1  input  1  requester 1 has an operation pending.
- A1  input  4  requester 1 multiplicand.
- B1  input  4  requester 1 multiplier.
- GNT1  output  1  requester 1 operands accepted this cycle.
- P  output  8  unsigned product of the served request.
- VALID  output  1  P and TAG hold a completed result.
- TAG  output  1  requester index that owns P.
- ACK  input  1  consumer takes the result.
- BUSY  output  1  unit not idle.
REQ-002 There SHALL be one clock; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.
REQ-003 The block SHALL have no parameters; all widths SHALL be fixed as listed.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-005 GNTx SHALL be combinational: high only in IDLE, only for the selected requester, and never both high.
REQ-006 In IDLE with exactly one REQx high, that requester SHALL be granted.
REQ-007 In IDLE with both REQ high, the requester named by a 1-bit priority pointer SHALL be granted.
REQ-008 On the grant edge the block SHALL:
- capture the granted A, B and index into internal registers;
- clear the 8-bit accumulator and the 2-bit step counter;
- go to CALC.
REQ-009 Operand inputs SHALL be ignored after the grant edge; changes to them SHALL NOT affect the in-flight result.
REQ-010 CALC step k (k = 0..3), one per clock: if captured A[k] = 1, the accumulator SHALL add (captured B zero-extended to 8 bits) << k; otherwise it SHALL hold.
REQ-011 All additions SHALL be 8-bit unsigned with no overflow possible (max 15 x 15 = 225).
REQ-012 After step 3 the state SHALL become DONE.
REQ-013 On entering DONE, P SHALL be loaded with the accumulator and TAG with the captured index.
REQ-014 Latency SHALL be fixed: VALID rises exactly 4 clocks after the grant edge, independent of operand values.
REQ-015 VALID SHALL be high in DONE only.
REQ-016 P and TAG SHALL remain stable in DONE until ACK is sampled high.
REQ-017 In DONE with ACK high, the block SHALL return to IDLE and set the priority pointer to the requester not just served.
REQ-018 ACK outside DONE SHALL be ignored.
REQ-019 REQx in CALC or DONE SHALL be ignored; no GNT SHALL be issued and no request SHALL be queued.
REQ-020 After leaving DONE, P and TAG SHALL hold their last values while VALID is low.
REQ-021 BUSY SHALL be high whenever state is not IDLE.
REQ-022 Minimum issue interval SHALL be 6 clocks: grant, 4 CALC, 1 DONE with ACK high, then grant again in IDLE.

Reset
REQ-023 While rst is high:
- state SHALL go to IDLE;
- P, TAG, the accumulator, the counter and the captured registers SHALL go to 0;
- the priority pointer SHALL go to requester 0.
REQ-024 rst SHALL override all other inputs.
REQ-025 While rst is high, GNT0, GNT1, VALID and BUSY SHALL be 0.
REQ-026 rst asserted mid-CALC or in DONE SHALL abort the operation with no VALID pulse.

Verification
REQ-027 After reset, REQ0=1, A0=3, B0=5 -> GNT0=1 for one cycle; 4 clocks later VALID=1, P=15, TAG=0.
REQ-028 A0=15, B0=15 -> P=225. A0=0, B0=9 -> P=0. Both with latency exactly 4.
REQ-029 Both REQ high from reset with A0=2, B0=7 and A1=9, B1=6 -> requester 0 served first with P=14, TAG=0; after ACK, requester 1 served with P=54, TAG=1.
REQ-030 Hold ACK=0 for 10 clocks in DONE while REQ0 and REQ1 are high -> VALID, P and TAG stable; GNT0=GNT1=0; BUSY=1.
REQ-031 rst pulse on the 2nd CALC cycle -> next cycle IDLE, BUSY=0, P=0, VALID never asserted; next grant goes to requester 0.
REQ-032 After grant with A0=5, B0=3, change A0 to 15 and B0 to 15 during CALC -> P=15.

Source files
------------

// File: rtl/mult4_sched.sv
// Two-requester 4x4 unsigned shift-add multiplier with round-robin grant.
// Fixed 4-cycle latency; result is held in DONE until acknowledged.
module mult4_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       REQ0,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  output logic       GNT0,
  input  logic       REQ1,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic       GNT1,
  output logic [7:0] P,
  output logic       VALID,
  output logic       TAG,
  input  logic       ACK,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t     state_q;
  logic       ptr_q;
  logic [3:0] a_q, b_q;
  logic       idx_q;
  logic [7:0] acc_q;
  logic [1:0] cnt_q;
  logic [7:0] p_q;
  logic       tag_q;

  logic       idle, sel1;
  logic [7:0] addend, acc_nxt;

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign idle = (state_q == IDLE) && !rst;
  assign sel1 = REQ1 && (!REQ0 || ptr_q);
  assign GNT1 = idle && sel1;
  assign GNT0 = idle && REQ0 && !sel1;

  assign addend  = a_q[cnt_q] ? ({4'b0000, b_q} << cnt_q) : 8'd0;
  assign acc_nxt = acc_q + addend;

  assign P     = p_q;
  assign TAG   = tag_q;
  assign VALID = (state_q == DONE) && !rst;
  assign BUSY  = (state_q != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      idx_q   <= 1'b0;
      acc_q   <= 8'd0;
      cnt_q   <= 2'd0;
      p_q     <= 8'd0;
      tag_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ0 || REQ1) begin
            a_q     <= sel1 ? A1 : A0;
            b_q     <= sel1 ? B1 : B0;
            idx_q   <= sel1;
            acc_q   <= 8'd0;
            cnt_q   <= 2'd0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            p_q     <= acc_nxt;
            tag_q   <= idx_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (ACK) begin
            ptr_q   <= ~idx_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
